// File: rtl/uart_rx_core.sv
// UART byte receiver (8N1, LSB first) with sticky ready flag and clear handshake.
// Optional UART_RX_GLITCH_FILTER_EN adds a registered 3-sample majority vote on the synchronized line.
module uart_rx_core #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic       rdy,
    output logic [7:0] rx_data,
    output logic       frm_err
);

    // state   | meaning
    // S_IDLE  | line idle, waiting for a falling edge on rx_s
    // S_START | half-bit wait, then confirm start bit is still low
    // S_DATA  | sampling 8 data bits at mid-bit
    // S_STOP  | sampling stop bit, delivering byte

    localparam int CW = ($clog2(BAUD_DIV) > 12) ? $clog2(BAUD_DIV) : 12;
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_rx_s_d;
    logic            w_rx_s;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_rdy;
    logic [7:0]      r_rx_data;
    logic            r_frm_err;

    logic            w_bit_tick;
    logic            w_cnt_load;
    logic [CW-1:0]   w_cnt_val;
    logic            w_start_det;
    logic            w_bit_clr;
    logic            w_shift_en;
    logic            w_deliver;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RX;
            r_sync2 <= r_sync1;
        end
    end

`ifdef UART_RX_GLITCH_FILTER_EN
    // Vote over both synchronizer stages plus the previous sample: a single-cycle
    // low never gets two votes, while a real edge costs only one extra cycle.
    logic r_rx_h;
    logic r_rx_maj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_h   <= 1'b1;
            r_rx_maj <= 1'b1;
        end else begin
            r_rx_h   <= r_sync2;
            r_rx_maj <= (r_sync1 & r_sync2) | (r_sync1 & r_rx_h) | (r_sync2 & r_rx_h);
        end
    end

    assign w_rx_s = r_rx_maj;
`else
    assign w_rx_s = r_sync2;
`endif

    assign w_bit_tick = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rx_s_d <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_rx_s_d <= w_rx_s;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_val   = FULL_M1;
        w_start_det = 1'b0;
        w_bit_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_deliver   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_rx_s_d && !w_rx_s) begin
                    w_start_det = 1'b1;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = HALF_M1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_tick) begin
                    if (w_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_load  = 1'b1;
                        w_bit_clr   = 1'b1;
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_bit_tick) begin
                    w_shift_en = 1'b1;
                    w_cnt_load = 1'b1;
                    if (r_bit_cnt == 4'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_tick) begin
                    w_deliver   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
        end else begin
            if (w_cnt_load) begin
                r_cnt <= w_cnt_val;
            end else if (!w_bit_tick) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_bit_clr) begin
                r_bit_cnt <= 4'd0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            if (w_shift_en) begin
                r_shift <= {w_rx_s, r_shift[7:1]};
            end
        end
    end

    // Delivery takes priority over a simultaneous clear so a fresh byte is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy     <= 1'b0;
            r_rx_data <= 8'h00;
            r_frm_err <= 1'b0;
        end else begin
            if (w_deliver) begin
                r_rdy     <= 1'b1;
                r_rx_data <= r_shift;
                r_frm_err <= ~w_rx_s;
            end else if (clr_rdy || w_start_det) begin
                r_rdy <= 1'b0;
            end
        end
    end

    assign rdy     = r_rdy;
    assign rx_data = r_rx_data;
    assign frm_err = r_frm_err;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core at BAUD_DIV=16; expected bytes, error flags and
// ready-rise cycles are queued when a frame is driven and compared on each rdy rise.
module tb_uart_rx_core;

    localparam int B = 16;
`ifdef UART_RX_GLITCH_FILTER_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       RX;
    logic       clr_rdy;
    logic       rdy;
    logic [7:0] rx_data;
    logic       frm_err;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc;
    int   n_chk;
    int   n_err;
    logic mon_prev;

    uart_rx_core #(.BAUD_DIV(B)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rdy     (rdy),
        .rx_data (rx_data),
        .frm_err (frm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Compare each rising rdy against the oldest queued frame.
    initial mon_prev = 1'b0;
    always @(negedge clk) begin
        if (rdy === 1'b1 && mon_prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexp_rdy", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_data", {24'h0, rx_data}, {24'h0, e.data});
                chk("sb_ferr", {31'h0, frm_err}, {31'h0, e.err});
                chk("sb_cycle", cyc, e.cyc);
            end
        end
        mon_prev <= rdy;
    end

    task automatic drive_bit(input logic v);
        RX = v;
        repeat (B) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input bit push, input bit chk_drop);
        int t0;
        t0 = cyc + 1;
        if (push) sb_q.push_back('{d, ~stop, t0 + 2 + B / 2 + 9 * B + LAT});
        drive_bit(1'b0);
        if (chk_drop) chk("b2b_rdy_drop", {31'h0, rdy}, 32'd0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_rdy = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int tt;
        n_chk   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        RX      = 1'b1;
        clr_rdy = 1'b0;
        idle(3);
        chk("rst_rdy", {31'h0, rdy}, 32'd0);
        chk("rst_data", {24'h0, rx_data}, 32'h00);
        chk("rst_ferr", {31'h0, frm_err}, 32'd0);
        rst_n = 1'b1;
        idle(4);

        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        chk("a5_rdy_held", {31'h0, rdy}, 32'd1);
        pulse_clr();
        chk("clr_rdy", {31'h0, rdy}, 32'd0);
        chk("clr_data_held", {24'h0, rx_data}, 32'hA5);

        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b1, 1'b1);
        idle(4);
        pulse_clr();

        RX = 1'b0;
        idle(4);
        RX = 1'b1;
        idle(12 * B);
        chk("fs_rdy", {31'h0, rdy}, 32'd0);
        chk("fs_data", {24'h0, rx_data}, 32'hC3);
        chk("fs_ferr", {31'h0, frm_err}, 32'd0);

        send_frame(8'h00, 1'b0, 1'b1, 1'b0);
        idle(3 * B);
        chk("brk_rdy", {31'h0, rdy}, 32'd1);
        chk("brk_data", {24'h0, rx_data}, 32'h00);
        chk("brk_ferr", {31'h0, frm_err}, 32'd1);
        RX = 1'b1;
        idle(B);
        send_frame(8'h81, 1'b1, 1'b1, 1'b0);
        idle(4);
        pulse_clr();

        tt = cyc + 1;
        fork
            send_frame(8'h96, 1'b1, 1'b1, 1'b0);
            begin
                while (cyc < tt + 153 + LAT) begin
                    @(posedge clk);
                    #1;
                end
                clr_rdy = 1'b1;
                @(posedge clk);
                #1;
                clr_rdy = 1'b0;
                chk("clr_vs_set", {31'h0, rdy}, 32'd1);
            end
        join
        idle(4);

        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rst_n = 1'b0;
        RX    = 1'b1;
        #1;
        chk("mid_rst_rdy", {31'h0, rdy}, 32'd0);
        chk("mid_rst_data", {24'h0, rx_data}, 32'h00);
        chk("mid_rst_ferr", {31'h0, frm_err}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(3);
        send_frame(8'hE7, 1'b1, 1'b1, 1'b0);
        idle(4);

        RX = 1'b0;
        idle(1);
        RX = 1'b1;
        idle(2 * B);
        chk("glitch_rdy", {31'h0, rdy}, (LAT == 1) ? 32'd1 : 32'd0);
        chk("glitch_data", {24'h0, rx_data}, 32'hE7);

        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 400 && sb_q.size() != 0; i++) idle(1);
        idle(4);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
